// File: rtl/irq_gateway_pkg.sv
// irq_gateway_pkg: shared types and defaults for the interrupt gateway.
// Optional glitch filter is enabled by IRQ_GATEWAY_GLITCH_FILTER_EN.
package irq_gateway_pkg;

  localparam int unsigned IRQ_MAX_DEF       = 32;
  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned FILTER_CYCLES_DEF = 4;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  function automatic int unsigned irq_id_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IRQ_ID_W = irq_id_w(IRQ_MAX_DEF);

endpackage

// File: rtl/irq_gateway_filter.sv
// irq_gateway_filter: per-line glitch filter on the synchronised level.
// Used only when IRQ_GATEWAY_GLITCH_FILTER_EN is defined.
module irq_gateway_filter
  import irq_gateway_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic s_i,
  output logic f_o
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            f_q;

  // f follows s only after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else if (s_i == f_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(FILTER_CYCLES - 1)) begin
      cnt_q <= '0;
      f_q   <= s_i;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign f_o = f_q;

endmodule

// File: rtl/irq_gateway.sv
// irq_gateway: sync, polarity, level/edge conditioning of interrupt lines.
// Define IRQ_GATEWAY_GLITCH_FILTER_EN to insert the per-line glitch filter.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter  int unsigned IRQ_MAX       = IRQ_MAX_DEF,
  parameter  int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter  int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
  localparam int unsigned IdW           = irq_id_w(IRQ_MAX)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IRQ_MAX-1:0] irq_raw_i,
  input  logic [IRQ_MAX-1:0] inv_i,
  input  logic [IRQ_MAX-1:0] edge_i,
  input  logic               clr_valid_i,
  input  logic [IdW-1:0]     clr_id_i,
  output logic [IRQ_MAX-1:0] irq_o,
  output logic [IRQ_MAX-1:0] overflow_o
);

  localparam int unsigned ArmCnt = SYNC_STAGES + 1;
  localparam int unsigned ArmW   = $clog2(ArmCnt + 1);

  logic [IRQ_MAX-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_MAX-1:0] s, f, x, rise, clr_hit;
  logic [IRQ_MAX-1:0] x_prev_q;
  logic [IRQ_MAX-1:0] pend_q, pend_d;
  logic [IRQ_MAX-1:0] ovf_q, ovf_d;
  logic [IRQ_MAX-1:0] irq_q, irq_d;
  logic [ArmW-1:0]    arm_cnt_q;
  logic               arm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_GATEWAY_GLITCH_FILTER_EN
  for (genvar g = 0; g < IRQ_MAX; g++) begin : g_filt
    irq_gateway_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .s_i   (s[g]),
      .f_o   (f[g])
    );
  end
`else
  assign f = s;
`endif

  // Hold off edge detection until the synchroniser has flushed reset zeros
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_cnt_q <= '0;
      arm_q     <= 1'b0;
    end else if (!arm_q) begin
      arm_cnt_q <= arm_cnt_q + 1'b1;
      arm_q     <= (arm_cnt_q == ArmW'(ArmCnt - 1));
    end
  end

  always_comb begin
    x    = f ^ inv_i;
    rise = x & ~x_prev_q & {IRQ_MAX{arm_q}};
    for (int i = 0; i < IRQ_MAX; i++) begin
      clr_hit[i] = clr_valid_i && (clr_id_i == IdW'(i));
    end
  end

  always_comb begin
    pend_d = '0;
    ovf_d  = '0;
    irq_d  = '0;
    for (int i = 0; i < IRQ_MAX; i++) begin
      unique case (irq_mode_e'(edge_i[i]))
        IRQ_EDGE: begin
          pend_d[i] = rise[i] | (pend_q[i] & ~clr_hit[i]);
          ovf_d[i]  = (ovf_q[i] | (rise[i] & pend_q[i])) & ~clr_hit[i];
          irq_d[i]  = pend_d[i];
        end
        IRQ_LEVEL: begin
          irq_d[i] = x[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_prev_q <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
      irq_q    <= '0;
    end else begin
      x_prev_q <= x;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o      = irq_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_irq_gateway.sv
// tb_irq_gateway: directed and random checks of irq_gateway.
// Reference model works from raw-input history by edge count.
module tb_irq_gateway;
  import irq_gateway_pkg::*;

  localparam int N    = 20;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int IDW  = irq_id_w(N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   raw, inv, edg;
  logic           clr_v;
  logic [IDW-1:0] clr_id;
  logic [N-1:0]   irq, ovf;

  always #5 clk = ~clk;

  irq_gateway #(
    .IRQ_MAX      (N),
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FILT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .irq_raw_i  (raw),
    .inv_i      (inv),
    .edge_i     (edg),
    .clr_valid_i(clr_v),
    .clr_id_i   (clr_id),
    .irq_o      (irq),
    .overflow_o (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state after each edge since reset release
  logic [N-1:0] raw_h [$];
  logic [N-1:0] s_h [$];
  logic [N-1:0] m_f, m_xprev, m_pend, m_ovf, m_irq;
  logic [N-1:0] s_cur, xin, x_cur, rise, hit;
  int unsigned  mk;
  logic         diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_h.delete();
      s_h.delete();
      m_f = '0; m_xprev = '0; m_pend = '0; m_ovf = '0; m_irq = '0;
    end else begin
      mk = raw_h.size() + 1;
      s_cur = (mk > SYNC) ? raw_h[mk-SYNC-1] : '0;
      s_h.push_back(s_cur);
`ifdef IRQ_GATEWAY_GLITCH_FILTER_EN
      xin = m_f;
      for (int i = 0; i < N; i++) begin
        diff = (s_h.size() >= FILT);
        for (int j = 0; j < FILT; j++)
          if (diff && s_h[s_h.size()-1-j][i] == m_f[i]) diff = 1'b0;
        if (diff) m_f[i] = ~m_f[i];
      end
`else
      xin = s_cur;
`endif
      x_cur = xin ^ inv;
      rise  = x_cur & ~m_xprev & {N{mk >= SYNC + 2}};
      hit   = clr_v ? (N'(1) << clr_id) : '0;
      for (int i = 0; i < N; i++) begin
        if (edg[i]) begin
          m_ovf[i]  = (m_ovf[i] | (rise[i] & m_pend[i])) & ~hit[i];
          m_pend[i] = rise[i] | (m_pend[i] & ~hit[i]);
          m_irq[i]  = m_pend[i];
        end else begin
          m_pend[i] = 1'b0;
          m_ovf[i]  = 1'b0;
          m_irq[i]  = x_cur[i];
        end
      end
      m_xprev = x_cur;
      raw_h.push_back(raw);
    end
  end

  always @(negedge clk) begin
    chk("irq_o_model", irq, m_irq);
    chk("overflow_o_model", ovf, m_ovf);
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse7();
    raw[7] = 1'b1;
    tick(2);
    raw[7] = 1'b0;
    tick(3);
  endtask

  initial begin
    raw    = '0;
    inv    = N'(1);
    edg    = '0;
    edg[0] = 1'b1;
    edg[5] = 1'b1;
    edg[7] = 1'b1;
    clr_v  = 1'b0;
    clr_id = '0;
    tick(2);
    chk("reset_irq", irq, 0);
    chk("reset_ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("inv0_idle", irq[0], 0);
    end

    raw[3] = 1'b1;
    tick(); chk("lvl3_e1", irq[3], 0);
    tick(); chk("lvl3_e2", irq[3], 0);
    tick(); chk("lvl3_e3", irq[3], 1);
    clr_v = 1'b1; clr_id = 5'd3;
    tick();
    clr_v = 1'b0;
    chk("lvl3_ack_ignored", irq[3], 1);
    tick(6);
    raw[3] = 1'b0;
    tick(); chk("lvl3_f1", irq[3], 1);
    tick(); chk("lvl3_f2", irq[3], 1);
    tick(); chk("lvl3_f3", irq[3], 0);

    raw[5] = 1'b1;
    tick(3);
    raw[5] = 1'b0;
    chk("edge5_set", irq[5], 1);
    tick(5);
    chk("edge5_hold", irq[5], 1);
    clr_v = 1'b1; clr_id = 5'd5;
    tick();
    clr_v = 1'b0;
    chk("edge5_ack", irq[5], 0);

    pulse7();
    chk("edge7_pend", irq[7], 1);
    chk("edge7_no_ovf", ovf[7], 0);
    pulse7();
    chk("edge7_ovf", ovf[7], 1);
    raw[7] = 1'b1;
    tick(2);
    raw[7] = 1'b0;
    clr_v = 1'b1; clr_id = 5'd7;
    tick();
    clr_v = 1'b0;
    chk("edge7_coinc_pend", irq[7], 1);
    chk("edge7_coinc_ovf", ovf[7], 0);
    tick(3);

    pulse7();
    chk("edge7_ovf2", ovf[7], 1);
    clr_v = 1'b1; clr_id = 5'd31;
    tick();
    clr_id = 5'd20;
    tick();
    clr_v = 1'b0;
    chk("oor_ack_irq", irq[7], 1);
    chk("oor_ack_ovf", ovf[7], 1);

    #1 rst_n = 1'b0;
    #1;
    chk("midrst_irq", irq, 0);
    chk("midrst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    tick(5);

`ifdef IRQ_GATEWAY_GLITCH_FILTER_EN
    raw[9] = 1'b1;
    tick(3);
    raw[9] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("filt_short", irq[9], 0);
    end
    raw[9] = 1'b1;
    tick(6);
    chk("filt_long_e6", irq[9], 0);
    raw[9] = 1'b0;
    tick();
    chk("filt_long_e7", irq[9], 1);
    tick(12);
`endif

    for (int seg = 0; seg < 6; seg++) begin
      inv = N'($urandom);
      edg = N'($urandom);
      if (seg == 3) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      for (int c = 0; c < 300; c++) begin
        raw    = raw ^ (N'($urandom) & N'($urandom) & N'($urandom));
        clr_v  = ($urandom_range(0, 2) == 0);
        clr_id = IDW'($urandom_range(0, 31));
        tick();
      end
    end
    clr_v = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
